// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response channel and the
// decoder-side handoff, plus the branch redirect inputs.
interface fetch_unit_if #(
    parameter int INSTRUCTION_WIDTH = 18,
    parameter int PC_WIDTH          = 14
);
    logic                         o_imem_req;
    logic [PC_WIDTH-1:0]          o_imem_addr;
    logic                         i_imem_ready;
    logic                         i_imem_rvalid;
    logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata;
    logic                         o_inst_valid;
    logic [INSTRUCTION_WIDTH-1:0] o_inst;
    logic [PC_WIDTH-1:0]          o_inst_pc;
    logic                         i_inst_ready;
    logic                         i_redirect;
    logic [PC_WIDTH-1:0]          i_redirect_pc;

    // Fetch unit side.
    modport master (
        output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  i_inst_ready, i_redirect, i_redirect_pc
    );

    // Memory / decoder environment side.
    modport slave (
        input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output i_inst_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, pairs in-order
// responses with their pc through a tag queue, buffers them for the decoder
// and discards stale responses after a redirect.
module fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 18,
    parameter int PC_WIDTH          = 14,
    parameter int FIFO_DEPTH        = 2,
    parameter int RESET_PC          = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_PC);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    // Circular pointer advance for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(FIFO_DEPTH - 1)) r = {PW{1'b0}};
        else                          r = p + PW'(1);
        return r;
    endfunction

    state_e                       state_q, state_d;
    logic [PC_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]                out_cnt_q, out_cnt_d;
    logic [CW-1:0]                fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]                discard_q, discard_d;
    logic [PW-1:0]                fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [PW-1:0]                tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [INSTRUCTION_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]          fifo_pc_q   [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]          fifo_pc_d   [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]          tag_q       [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]          tag_d       [FIFO_DEPTH];

    logic req_s, issue_s, rsp_s, push_s, pop_s;

    // Handshake strobes; request credit ignores a same-cycle pop on purpose.
    always_comb begin
        req_s   = i_rst & ~bus.i_redirect &
                  ((SW'(out_cnt_q) + SW'(fifo_cnt_q)) < SW'(FIFO_DEPTH));
        issue_s = req_s & bus.i_imem_ready;
        rsp_s   = bus.i_imem_rvalid & (out_cnt_q != {CW{1'b0}});
        push_s  = rsp_s & (discard_q == {CW{1'b0}}) & ~bus.i_redirect;
        pop_s   = (fifo_cnt_q != {CW{1'b0}}) & bus.i_inst_ready;
    end

    // Next-state: counters, pointers, storage writes and RUN/DRAIN control.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        fifo_cnt_d  = fifo_cnt_q;
        discard_d   = discard_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;
        tag_d       = tag_q;

        // Stale requests stay counted so total in-flight never exceeds the buffer.
        if (issue_s && !rsp_s) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!issue_s && rsp_s) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end else begin
            out_cnt_d = out_cnt_q;
        end

        if (bus.i_redirect) begin
            fetch_pc_d = bus.i_redirect_pc;
            fifo_cnt_d = {CW{1'b0}};
            fifo_rd_d  = {PW{1'b0}};
            fifo_wr_d  = {PW{1'b0}};
            tag_rd_d   = {PW{1'b0}};
            tag_wr_d   = {PW{1'b0}};
            discard_d  = rsp_s ? (out_cnt_q - CW'(1)) : out_cnt_q;
        end else begin
            if (issue_s) begin
                fetch_pc_d      = fetch_pc_q + PC_WIDTH'(1);
                tag_d[tag_wr_q] = fetch_pc_q;
                tag_wr_d        = ptr_inc(tag_wr_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_s && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - CW'(1);
            end else if (rsp_s) begin
                tag_rd_d = ptr_inc(tag_rd_q);
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                fifo_inst_d[fifo_wr_q] = bus.i_imem_rdata;
                fifo_pc_d[fifo_wr_q]   = tag_q[tag_rd_q];
                fifo_wr_d              = ptr_inc(fifo_wr_q);
            end else begin
                fifo_wr_d = fifo_wr_q;
            end
            if (pop_s) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end else begin
                fifo_rd_d = fifo_rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end

        case (state_q)
            ST_RUN:   state_d = (bus.i_redirect && (discard_d != {CW{1'b0}})) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = (discard_d == {CW{1'b0}}) ? ST_RUN : ST_DRAIN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Outputs: request from registered state, FIFO head zeroed while empty.
    always_comb begin
        bus.o_imem_req   = req_s;
        bus.o_imem_addr  = fetch_pc_q;
        bus.o_inst_valid = (fifo_cnt_q != {CW{1'b0}});
        if (fifo_cnt_q != {CW{1'b0}}) begin
            bus.o_inst    = fifo_inst_q[fifo_rd_q];
            bus.o_inst_pc = fifo_pc_q[fifo_rd_q];
        end else begin
            bus.o_inst    = {INSTRUCTION_WIDTH{1'b0}};
            bus.o_inst_pc = {PC_WIDTH{1'b0}};
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_ADDR;
            out_cnt_q  <= {CW{1'b0}};
            fifo_cnt_q <= {CW{1'b0}};
            discard_q  <= {CW{1'b0}};
            fifo_rd_q  <= {PW{1'b0}};
            fifo_wr_q  <= {PW{1'b0}};
            tag_rd_q   <= {PW{1'b0}};
            tag_wr_q   <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            discard_q  <= discard_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Buffer and tag storage; entries only become visible through the counts.
    always_ff @(posedge i_clk) begin
        fifo_inst_q <= fifo_inst_d;
        fifo_pc_q   <= fifo_pc_d;
        tag_q       <= tag_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the basic flow and a
// redirect drain, plus hand sequences driven by a one-cycle-latency memory.
module tb_fetch_unit;
    localparam int IW = 18;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(AW)) bus ();

    fetch_unit #(
        .INSTRUCTION_WIDTH(IW), .PC_WIDTH(AW), .FIFO_DEPTH(2), .RESET_PC(0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic          rdy;
        logic          rv;
        logic [AW-1:0] rd_pc;
        logic          iready;
        logic          redir;
        logic [AW-1:0] rpc;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [AW-1:0] e_pc;
    } vec_t;

    vec_t          vecs[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_issue  = 0;
    logic          s_req, s_valid;
    logic [AW-1:0] s_addr, s_pc;
    logic [IW-1:0] s_inst;
    logic [AW-1:0] pending[$];
    logic [AW-1:0] delivered[$];
    logic [IW-1:0] delivered_inst[$];

    function automatic logic [IW-1:0] mk(input logic [AW-1:0] a);
        return {4'hA, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic rdy, rv, input logic [AW-1:0] rd_pc, input logic iready, redir,
                       input logic [AW-1:0] rpc, input logic e_req, input logic [AW-1:0] e_addr,
                       input logic e_valid, input logic [AW-1:0] e_pc);
        vec_t v;
        v = '{rdy, rv, rd_pc, iready, redir, rpc, e_req, e_addr, e_valid, e_pc};
        vecs.push_back(v);
    endtask

    // One cycle: drive on the falling edge, sample 1 ns later, end on the rising edge.
    task automatic drive(input logic rst, rdy, rv, input logic [AW-1:0] rd_pc,
                         input logic iready, redir, input logic [AW-1:0] rpc);
        @(negedge clk);
        rst_n             = rst;
        bus.i_imem_ready  = rdy;
        bus.i_imem_rvalid = rv;
        bus.i_imem_rdata  = mk(rd_pc);
        bus.i_inst_ready  = iready;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        #1;
        s_req   = bus.o_imem_req;
        s_addr  = bus.o_imem_addr;
        s_valid = bus.o_inst_valid;
        s_pc    = bus.o_inst_pc;
        s_inst  = bus.o_inst;
        @(posedge clk);
    endtask

    // Cycle with the memory model: answers each issue on the following cycle unless held.
    task automatic step(input logic rst, rdy, iready, redir, input logic [AW-1:0] rpc, input logic hold);
        logic          rv;
        logic [AW-1:0] rd_pc;
        rv    = (pending.size() > 0) && !hold;
        rd_pc = '0;
        if (rv) rd_pc = pending[0];
        drive(rst, rdy, rv, rd_pc, iready, redir, rpc);
        if (rv) pending.delete(0);
        if (s_req && rdy) begin
            pending.push_back(s_addr);
            n_issue++;
        end
        if (s_valid && iready) begin
            delivered.push_back(s_pc);
            delivered_inst.push_back(s_inst);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 14'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 14'h0, 1'b1);
        pending.delete();
        delivered.delete();
        delivered_inst.delete();
        n_issue = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_imem_ready = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
        bus.i_inst_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = '0;

        // rdy rv rd_pc iready redir rpc | req addr valid pc
        add(1, 0, 14'h000, 1, 0, 14'h000, 1, 14'h000, 0, 14'h000);
        add(1, 1, 14'h000, 1, 0, 14'h000, 1, 14'h001, 0, 14'h000);
        add(1, 1, 14'h001, 1, 0, 14'h000, 0, 14'h002, 1, 14'h000);
        add(1, 0, 14'h000, 1, 0, 14'h000, 1, 14'h002, 1, 14'h001);
        add(1, 1, 14'h002, 1, 0, 14'h000, 1, 14'h003, 0, 14'h000);
        add(1, 1, 14'h003, 1, 0, 14'h000, 0, 14'h004, 1, 14'h002);
        add(0, 0, 14'h000, 1, 0, 14'h000, 1, 14'h004, 1, 14'h003);
        add(1, 0, 14'h000, 1, 0, 14'h000, 1, 14'h004, 0, 14'h000);
        add(1, 0, 14'h000, 1, 0, 14'h000, 1, 14'h005, 0, 14'h000);
        add(1, 0, 14'h000, 1, 1, 14'h100, 0, 14'h006, 0, 14'h000);
        add(1, 1, 14'h004, 1, 0, 14'h000, 0, 14'h100, 0, 14'h000);
        add(1, 1, 14'h005, 1, 0, 14'h000, 1, 14'h100, 0, 14'h000);
        add(0, 1, 14'h100, 1, 0, 14'h000, 1, 14'h101, 0, 14'h000);
        add(0, 0, 14'h000, 1, 0, 14'h000, 1, 14'h101, 1, 14'h100);
        add(0, 0, 14'h000, 1, 0, 14'h000, 1, 14'h101, 0, 14'h000);

        // Reset values.
        drive(1'b0, 1'b1, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0);
        drive(1'b0, 1'b1, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0);
        check("rst_req", s_req, 0);
        check("rst_addr", s_addr, 0);
        check("rst_valid", s_valid, 0);
        check("rst_inst", s_inst, 0);
        check("rst_pc", s_pc, 0);

        // Table: streaming fetch, then redirect with two stale responses.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].rdy, vecs[i].rv, vecs[i].rd_pc, vecs[i].iready,
                  vecs[i].redir, vecs[i].rpc);
            check($sformatf("v%0d_req", i), s_req, vecs[i].e_req);
            check($sformatf("v%0d_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), s_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i), s_pc, vecs[i].e_pc);
                check($sformatf("v%0d_inst", i), s_inst, mk(vecs[i].e_pc));
            end
        end

        // Decoder stalled: buffer fills, head held, then drains without loss.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0);
            if (s_valid) begin
                check("stall_pc", s_pc, 0);
                check("stall_inst", s_inst, mk(14'h0));
            end
        end
        check("stall_issues", n_issue, 2);
        check("stall_req", s_req, 0);
        check("stall_valid", s_valid, 1);
        for (int i = 0; i < 20 && delivered.size() < 3; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("stall_count", delivered.size() >= 3, 1);
        for (int k = 0; k < 3; k++)
            if (k < delivered.size()) check($sformatf("stall_seq%0d", k), delivered[k], k);

        // Redirect in the same cycle as a response and a pop.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 14'h200, 1'b0);
        check("rdr_req", s_req, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("rdr_next_req", s_req, 1);
        check("rdr_next_addr", s_addr, 14'h200);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("rdr_count", delivered.size() >= 3, 1);
        if (delivered.size() >= 3) begin
            check("rdr_seq0", delivered[0], 14'h000);
            check("rdr_seq1", delivered[1], 14'h200);
            check("rdr_seq2", delivered[2], 14'h201);
            check("rdr_inst1", delivered_inst[1], mk(14'h200));
        end

        // Address wrap, then reset with two requests in flight.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 14'h3FFF, 1'b0);
        check("wrap_rdr_req", s_req, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b1);
        check("wrap_addr0", s_addr, 14'h3FFF);
        check("wrap_req0", s_req, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b1);
        check("wrap_addr1", s_addr, 14'h0000);
        check("wrap_req1", s_req, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("mid_rst_req", s_req, 0);
        check("mid_rst_valid", s_valid, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("post_rst_addr", s_addr, 14'h0000);
        check("post_rst_valid", s_valid, 0);
        check("post_rst_inst", s_inst, 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 14'h0, 1'b0);
        check("post_rst_count", delivered.size() >= 3, 1);
        for (int k = 0; k < 3; k++)
            if (k < delivered.size()) begin
                check($sformatf("post_rst_seq%0d", k), delivered[k], k);
                check($sformatf("post_rst_inst%0d", k), delivered_inst[k], mk(AW'(k)));
            end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 18, instruction word width.
REQ-002 SHALL have parameter PC_WIDTH, default 14, word address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, prefetch buffer entries and maximum outstanding requests.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL operate on one clock with a synchronous, active-low reset.
REQ-006 i_clk  input  1  clock; all state updates on rising edge.
REQ-007 i_rst  input  1  synchronous active-low reset.
REQ-008 o_imem_req  output  1  fetch request valid.
REQ-009 o_imem_addr  output  PC_WIDTH  fetch word address.
REQ-010 i_imem_ready  input  1  memory accepts request this cycle (req & ready = issue).
REQ-011 i_imem_rvalid  input  1  in-order read response valid.
REQ-012 i_imem_rdata  input  INSTRUCTION_WIDTH  response instruction word.
REQ-013 o_inst_valid  output  1  instruction available to decoder.
REQ-014 o_inst  output  INSTRUCTION_WIDTH  instruction to decoder.
REQ-015 o_inst_pc  output  PC_WIDTH  address of o_inst.
REQ-016 i_inst_ready  input  1  decoder consumes (valid & ready = pop).
REQ-017 i_redirect  input  1  branch taken; flush and refetch.
REQ-018 i_redirect_pc  input  PC_WIDTH  redirect target.

Function
REQ-019 SHALL keep fetch_pc, outstanding count (0..FIFO_DEPTH), FIFO count (0..FIFO_DEPTH), discard count, and FIFO storage of {instruction, pc} pairs.
REQ-020 SHALL drive o_imem_req = 1 only when not in reset, i_redirect = 0, and outstanding + FIFO count < FIFO_DEPTH (combinational from registered state, no same-cycle pop credit).
REQ-021 SHALL drive o_imem_addr = fetch_pc; on issue fetch_pc increments by 1, wrapping 2^PC_WIDTH-1 -> 0.
REQ-022 SHALL record the issued address in an in-order tag queue so each response is paired with its pc.
REQ-023 SHALL increment outstanding on issue, decrement on i_imem_rvalid; both in one cycle leave it unchanged.
REQ-024 SHALL push {i_imem_rdata, tagged pc} on i_imem_rvalid when discard count = 0; overflow is impossible by REQ-020.
REQ-025 SHALL present FIFO head on o_inst/o_inst_pc with o_inst_valid = (FIFO count > 0); no bypass: earliest o_inst_valid is the cycle after rvalid.
REQ-026 SHALL hold o_inst/o_inst_pc stable while o_inst_valid = 1 and i_inst_ready = 0.
REQ-027 SHALL support push and pop in the same cycle at any count, including full.
REQ-028 SHALL implement states RUN and DRAIN: RUN -> DRAIN on redirect when stale requests remain in flight; DRAIN -> RUN when discard count reaches 0; redirect in DRAIN reloads discard count.
REQ-029 On i_redirect = 1: FIFO count <= 0, fetch_pc <= i_redirect_pc, tag queue cleared, discard count <= outstanding minus 1 if i_imem_rvalid same cycle, else outstanding; o_imem_req = 0 that cycle.
REQ-030 A pop coinciding with redirect SHALL count as consumed; a response coinciding with redirect SHALL be dropped.
REQ-031 In DRAIN, each i_imem_rvalid SHALL decrement discard count and not push; new requests to the redirect target MAY issue in DRAIN under REQ-020.
REQ-032 i_imem_rvalid with outstanding = 0 SHALL be ignored without state change.

Reset
REQ-033 While i_rst = 0 at a clock edge: fetch_pc <= RESET_PC, all counts 0, state RUN.
REQ-034 During and the cycle after reset: o_imem_req = 0 during reset, o_imem_addr = RESET_PC, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight responses and buffered instructions; responses arriving after reset release with outstanding = 0 are ignored per REQ-032.

Verification
REQ-036 Reset release, ready = 1, rvalid one cycle after each issue, decoder ready = 1 -> addresses 0,1,2 issued; o_inst_pc sequence 0,1,2 in order, with valid first asserted 2 cycles after first issue.
REQ-037 Decoder ready = 0 for 10 cycles -> exactly 2 requests issued, FIFO full, o_imem_req = 0, o_inst stable at pc 0; ready = 1 -> pcs 0,1,2 delivered without loss.
REQ-038 Two requests outstanding (pc 4,5), redirect to 0x100 -> two late responses dropped, next o_inst_pc = 0x100, no pc 4/5 delivered.
REQ-039 Redirect same cycle as rvalid and pop -> response dropped, popped instruction not repeated, discard count = outstanding-1.
REQ-040 fetch_pc = 0x3FFF, two issues -> addresses 0x3FFF then 0x0000; reset asserted with 2 outstanding -> no instruction delivered, next fetch at RESET_PC.
